// File: rtl/udp_tx_payload_buffer_pkg.sv
// udp_tx_payload_buffer_pkg: header lengths, payload limits and FSM state encoding
package udp_tx_payload_buffer_pkg;
  localparam int UDP_HDR_LEN = 8;
  localparam int IP_HDR_LEN = 20;
  localparam int MIN_PAYLOAD = 18;
  localparam int MAX_PAYLOAD = 1472;
  typedef enum logic [1:0] {FILL, DROP, SEND, GAP} state_t;
endpackage

// File: rtl/udp_tx_payload_buffer_if.sv
// udp_tx_payload_buffer_if: byte AXI-Stream bundle (tdata/tvalid/tready/tlast/tuser) with master/slave modports
interface udp_tx_payload_buffer_if;
  logic [7:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  logic tuser;
  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/udp_tx_payload_buffer_sdp_ram_byte.sv
// sdp_ram_byte: byte RAM, write port (i_we/i_waddr/i_wdata), read port (i_re/i_raddr) with registered o_rdata
module sdp_ram_byte #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);
  logic [7:0] r_mem [2**ADDR_W];
  logic [7:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/udp_tx_payload_buffer.sv
// udp_tx_payload_buffer: store-and-forward UDP payload buffer; s_axis in, m_axis out (padded), UDP_TotLen/IP_TotLen, drop_pulse
module udp_tx_payload_buffer
  import udp_tx_payload_buffer_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int MAX_PAYLOAD = udp_tx_payload_buffer_pkg::MAX_PAYLOAD,
  parameter int MIN_PAYLOAD = udp_tx_payload_buffer_pkg::MIN_PAYLOAD,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                           s_axis_aclk,
  input  logic                           rst,
  udp_tx_payload_buffer_if.slave         s_axis,
  udp_tx_payload_buffer_if.master        m_axis,
  output logic [15:0]                    UDP_TotLen,
  output logic [15:0]                    IP_TotLen,
  output logic                           drop_pulse
);
  localparam int CW = ADDR_W + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] r_gap;
  logic [15:0] r_len, r_rd_idx, r_f_idx, r_udp, r_ip, w_cnt16, w_cnt1, w_len;
  logic [7:0] r_m_data, w_rdata;
  logic r_f_vld, r_m_vld, r_m_last, r_m_user, r_drop;
  logic w_rdy, w_acc, w_full, w_drop, w_good, w_we, w_adv, w_re, w_done;
  assign w_acc   = s_axis.tvalid && w_rdy;
  assign w_full  = r_cnt == CW'(MAX_PAYLOAD);
  assign w_cnt16 = 16'(r_cnt);
  assign w_cnt1  = w_cnt16 + 16'd1;
  assign w_len   = w_cnt1 < 16'(MIN_PAYLOAD) ? 16'(MIN_PAYLOAD) : w_cnt1;
  assign w_drop  = w_acc && s_axis.tlast && (r_state == DROP || w_full || s_axis.tuser);
  assign w_good  = r_state == FILL && w_acc && s_axis.tlast && !w_full && !s_axis.tuser;
  assign w_we    = r_state == FILL && w_acc && !w_full;
  assign w_adv   = r_state == SEND && (!r_m_vld || m_axis.tready);
  assign w_re    = w_adv && r_rd_idx < r_len;
  assign w_done  = r_m_vld && m_axis.tready && r_m_last;
  always_comb begin
    w_next = r_state;
    w_rdy  = r_state == FILL || r_state == DROP;
    case (r_state)
      FILL:    w_next = w_good ? SEND : (w_acc && w_full && !s_axis.tlast) ? DROP : FILL;
      DROP:    w_next = w_drop ? FILL : DROP;
      SEND:    w_next = w_done ? GAP : SEND;
      GAP:     w_next = r_gap == GW'(GAP_CYCLES - 1) ? FILL : GAP;
      default: w_next = FILL;
    endcase
  end
  always_ff @(posedge s_axis_aclk) r_state <= rst ? FILL : w_next;
  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_gap    <= '0;
      r_len    <= '0;
      r_udp    <= '0;
      r_ip     <= '0;
      r_drop   <= 1'b0;
      r_rd_idx <= '0;
      r_f_idx  <= '0;
      r_f_vld  <= 1'b0;
      r_m_vld  <= 1'b0;
      r_m_data <= '0;
      r_m_last <= 1'b0;
      r_m_user <= 1'b0;
    end else begin
      r_drop <= w_drop;
      r_gap  <= r_state == GAP ? r_gap + GW'(1) : '0;
      if (w_drop || (r_state == GAP && w_next == FILL)) r_cnt <= '0;
      else if (w_we) r_cnt <= r_cnt + CW'(1);
      if (w_good) begin
        r_len <= w_len;
        r_udp <= w_len + 16'(UDP_HDR_LEN);
        r_ip  <= w_len + 16'(UDP_HDR_LEN + IP_HDR_LEN);
      end
      if (r_state != SEND) begin
        r_rd_idx <= '0;
        r_f_vld  <= 1'b0;
        r_m_vld  <= 1'b0;
      end else if (w_adv) begin
        r_m_vld  <= r_f_vld;
        r_m_data <= r_f_vld && r_f_idx < w_cnt16 ? w_rdata : 8'h00;
        r_m_last <= r_f_vld && r_f_idx == r_len - 16'd1;
        r_m_user <= r_f_vld && r_f_idx == 16'd0;
        r_f_vld  <= w_re;
        r_f_idx  <= r_rd_idx;
        r_rd_idx <= w_re ? r_rd_idx + 16'd1 : r_rd_idx;
      end
    end
  end
  sdp_ram_byte #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (s_axis_aclk),
    .i_we    (w_we),
    .i_waddr (r_cnt[ADDR_W-1:0]),
    .i_wdata (s_axis.tdata),
    .i_re    (w_re),
    .i_raddr (r_rd_idx[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );
  assign s_axis.tready = w_rdy;
  assign m_axis.tvalid = r_m_vld;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tlast  = r_m_last;
  assign m_axis.tuser  = r_m_user;
  assign UDP_TotLen    = r_udp;
  assign IP_TotLen     = r_ip;
  assign drop_pulse    = r_drop;
endmodule
